// File: rtl/mcb_frame_reader.sv
// Streams one frame buffer from an MCB read port onto a valid/ready pixel stream.
// Define FRAME_LOOP_EN to wrap frames continuously instead of stopping after one.
module mcb_frame_reader #(
    parameter int          BURST_WORDS = 32,
    parameter int          FRAME_WORDS = 153600,
    parameter logic [29:0] BASE_ADDR   = 30'h0,
    parameter int          FIFO_DEPTH  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        calib_done,
    input  logic        frame_start,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_empty,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        frame_done
);
    localparam int FW = $clog2(FRAME_WORDS + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [29:0] ADDR_STEP = 30'(4 * BURST_WORDS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state;
    logic [FW-1:0] issued, consumed;
    logic [CW-1:0] local_count, outstanding;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   mem [FIFO_DEPTH];
    logic          credit_ok, pix_xfer, last_word;

    assign cmd_instr = 3'b001;
    assign cmd_bl    = 6'(BURST_WORDS - 1);
    assign rd_en     = !rd_empty;
    assign pix_valid = (local_count != '0);
    assign pix_data  = mem[rd_ptr];
    assign pix_xfer  = pix_valid && pix_ready;
    assign last_word = pix_xfer && (consumed == FW'(FRAME_WORDS - 1));

    // Reserve room for every word already requested so the MCB read FIFO can always drain.
    assign credit_ok = (SW'(local_count) + SW'(outstanding) + SW'(BURST_WORDS)) <= SW'(FIFO_DEPTH);
    // cmd_en follows cmd_full combinationally so a command is never strobed into a full FIFO.
    assign cmd_en    = (state == ISSUE) && !cmd_full && credit_ok && (issued < FW'(FRAME_WORDS));

    always_ff @(posedge clk) begin
        if (rd_en) mem[wr_ptr] <= rd_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            local_count <= '0;
            outstanding <= '0;
        end else begin
            if (rd_en)    wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pix_xfer) rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            local_count <= local_count + CW'(rd_en) - CW'(pix_xfer);
            outstanding <= outstanding + (cmd_en ? CW'(BURST_WORDS) : CW'(0)) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            cmd_byte_addr <= BASE_ADDR;
            issued        <= '0;
            consumed      <= '0;
        end else begin
            frame_done <= last_word;
            if (pix_xfer) consumed <= last_word ? '0 : consumed + 1'b1;
            case (state)
                IDLE: begin
                    if (frame_start && calib_done) begin
                        state         <= ISSUE;
                        busy          <= 1'b1;
                        issued        <= '0;
                        consumed      <= '0;
                        cmd_byte_addr <= BASE_ADDR;
                    end
                end
                ISSUE: begin
                    if (cmd_en) begin
                        if (issued == FW'(FRAME_WORDS - BURST_WORDS)) begin
`ifdef FRAME_LOOP_EN
                            issued        <= '0;
                            cmd_byte_addr <= BASE_ADDR;
`else
                            issued        <= FW'(FRAME_WORDS);
                            cmd_byte_addr <= cmd_byte_addr + ADDR_STEP;
                            state         <= DRAIN;
`endif
                        end else begin
                            issued        <= issued + FW'(BURST_WORDS);
                            cmd_byte_addr <= cmd_byte_addr + ADDR_STEP;
                        end
                    end
                end
                DRAIN: begin
                    if (last_word) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mcb_frame_reader.sv
// Bench for mcb_frame_reader: MCB port model returning word = byte address, stream scoreboard.
module tb_mcb_frame_reader;
    localparam int BURST = 32;
    localparam int FRAME = 128;
    localparam int DEPTH = 64;
    localparam logic [31:0] BASE = 32'h1000;

    logic        clk, reset, calib_done, frame_start;
    logic        cmd_en, cmd_full, rd_en, rd_empty, pix_valid, pix_ready, busy, frame_done;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic [31:0] rd_data, pix_data;

    mcb_frame_reader #(
        .BURST_WORDS(BURST), .FRAME_WORDS(FRAME), .BASE_ADDR(30'h1000), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .calib_done(calib_done), .frame_start(frame_start),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_full(cmd_full), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0, bad = 0;
    int ncmd = 0, nacc = 0, nfd = 0, occ = 0;
    int c0, w0, f0;
    int ready_mode = 0;
    logic [31:0] mcb_q[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // MCB port model and stream scoreboard; samples on negedge, updates read FIFO after posedge.
    initial begin
        logic [31:0] next_addr, hold_d;
        logic        fd_exp, hold_v;
        next_addr = BASE; fd_exp = 1'b0; hold_v = 1'b0; hold_d = '0;
        rd_empty = 1'b1; rd_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mcb_q.delete(); exp_q.delete();
                ncmd = 0; nacc = 0; nfd = 0; occ = 0;
                next_addr = BASE; fd_exp = 1'b0; hold_v = 1'b0;
            end else begin
                chk("frame_done", frame_done, fd_exp);
                if (frame_done) nfd++;
                fd_exp = 1'b0;
                chk("pix_valid", pix_valid, exp_q.size() != 0);
                chk("rd_en", rd_en, mcb_q.size() != 0);
                if (hold_v) chk("hold_data", pix_data, hold_d);
                hold_v = pix_valid && !pix_ready;
                hold_d = pix_data;
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) chk("extra_word", 1, 0);
                    else chk("pix_data", pix_data, exp_q.pop_front());
                    nacc++; occ--;
                    if (nacc % FRAME == 0) fd_exp = 1'b1;
                end
                if (rd_en && mcb_q.size() != 0) begin
                    exp_q.push_back(mcb_q.pop_front());
                    occ++;
                end
                if (cmd_en && !cmd_full) begin
                    ncmd++;
                    chk("cmd_addr", 32'(cmd_byte_addr), next_addr);
                    chk("cmd_instr", 32'(cmd_instr), 1);
                    chk("cmd_bl", 32'(cmd_bl), BURST - 1);
                    for (int i = 0; i < BURST; i++) mcb_q.push_back(32'(cmd_byte_addr) + 32'(4 * i));
                    next_addr = (next_addr == BASE + 4 * (FRAME - BURST)) ? BASE : next_addr + 4 * BURST;
                end
                chk("occupancy", 32'(occ > DEPTH), 0);
            end
            @(posedge clk); #1;
            rd_empty = (mcb_q.size() == 0);
            rd_data  = rd_empty ? '0 : mcb_q[0];
        end
    end

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = 1'b0;
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    typedef struct {
        int hold_mode; int hold_cyc; int hold_cmds; int hold_occ;
        int run_mode;  int exp_cmds; int exp_words; int exp_fd;
    } vec_t;
    vec_t vt[3];

    task automatic step;
        @(posedge clk); #3;
    endtask

    task automatic snap;
        c0 = ncmd; w0 = nacc; f0 = nfd;
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin step(); n++; end while (busy && n < budget);
        chk("idle_timeout", busy, 0);
        repeat (2) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_en"}, cmd_en, 0);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_addr"}, 32'(cmd_byte_addr), BASE);
    endtask

    task automatic chk_frame(input string tag, input int cmds, input int words, input int fds);
        chk({tag, "_cmds"}, ncmd - c0, cmds);
        chk({tag, "_words"}, nacc - w0, words);
        chk({tag, "_frame_done_cnt"}, nfd - f0, fds);
        chk({tag, "_leftover"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; calib_done = 1'b0; frame_start = 1'b0; cmd_full = 1'b0;
        vt[0] = '{0, 0,   0, 0,  0, 4, FRAME, 1};
        vt[1] = '{1, 100, 2, 64, 0, 4, FRAME, 1};
        vt[2] = '{2, 0,   0, 0,  2, 4, FRAME, 1};
        repeat (3) step();
        chk_reset_vals("rst");
        chk("rst_instr", 32'(cmd_instr), 1);
        chk("rst_bl", 32'(cmd_bl), BURST - 1);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) step();

        // frame_start before calibration is dropped
        pulse_start();
        repeat (20) step();
        chk("nocal_cmds", ncmd, 0);
        chk("nocal_busy", busy, 0);
        calib_done = 1'b1;

`ifdef FRAME_LOOP_EN
        snap();
        ready_mode = 2;
        pulse_start();
        n = 0;
        while (nfd - f0 < 3 && n < 5000) begin step(); n++; end
        chk("loop_frames", nfd - f0, 3);
        chk("loop_words", 32'(nacc - w0 >= 3 * FRAME), 1);
        chk("loop_busy", busy, 1);
        @(posedge clk); #1 reset = 1'b1;
        #2 chk_reset_vals("loop_rst");
        @(posedge clk); #1 reset = 1'b0;
`else
        for (int k = 0; k < 3; k++) begin
            snap();
            ready_mode = vt[k].hold_mode;
            pulse_start();
            if (vt[k].hold_cyc > 0) begin
                repeat (vt[k].hold_cyc) step();
                chk("bp_cmds", ncmd - c0, vt[k].hold_cmds);
                chk("bp_occ", occ, vt[k].hold_occ);
                chk("bp_valid", pix_valid, 1);
            end
            ready_mode = vt[k].run_mode;
            wait_idle(3000);
            chk_frame($sformatf("vec%0d", k), vt[k].exp_cmds, vt[k].exp_words, vt[k].exp_fd);
        end

        // cmd_full asserted ahead of the third command
        snap();
        ready_mode = 0;
        pulse_start();
        n = 0;
        while (ncmd - c0 < 2 && n < 200) begin step(); n++; end
        chk("full_wait", ncmd - c0, 2);
        cmd_full = 1'b1;
        repeat (50) begin step(); chk("full_cmd_en", cmd_en, 0); end
        chk("full_cmds", ncmd - c0, 2);
        cmd_full = 1'b0;
        wait_idle(3000);
        chk_frame("full", 4, FRAME, 1);

        // second frame_start mid-frame is ignored
        snap();
        pulse_start();
        repeat (60) step();
        pulse_start();
        wait_idle(3000);
        chk_frame("midstart", 4, FRAME, 1);

        // reset after 50 words, then a clean frame
        snap();
        ready_mode = 2;
        pulse_start();
        n = 0;
        while (nacc - w0 < 50 && n < 2000) begin step(); n++; end
        chk("rst_wait", 32'(nacc - w0 >= 50), 1);
        @(posedge clk); #1 reset = 1'b1;
        #2 chk_reset_vals("midrst");
        repeat (3) step();
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) step();
        snap();
        ready_mode = 0;
        pulse_start();
        wait_idle(3000);
        chk_frame("postrst", 4, FRAME, 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
